// File: rtl/alu_check_stage.sv
// alu_check_stage: self-checking wrapper around a combinational ALU.
// Accepts test vectors over valid/ready and drives them onto the ALU.
// After a settle window it compares the ALU outputs with the expected values
// and keeps saturating pass/fail tallies plus the index of the first failure.
module alu_check_stage #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [2:0]       vec_f,
    input  logic [WIDTH-1:0] vec_a,
    input  logic [WIDTH-1:0] vec_b,
    input  logic [WIDTH-1:0] vec_y,
    input  logic             vec_zero,
    input  logic             vec_last,
    output logic [2:0]       alu_f,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_valid,
    output logic             mismatch,
    output logic             done
);

    // Settle counter only ever holds SETTLE-1.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [SW-1:0]    settle_cnt;
    logic [WIDTH-1:0] exp_y;
    logic             exp_zero;
    logic             exp_last;
    logic [CNT_W-1:0] idx;
    logic             accept;
    logic             sample;
    logic             match;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign accept = vec_valid && vec_ready;
    assign sample = (state == WAIT) && (settle_cnt == '0);
    // An X/Z anywhere makes match non-1, which lands in the mismatch branch.
    assign match  = (alu_y == exp_y) && (alu_zero == exp_zero);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state: one vector in flight at a time, DONE is terminal until reset.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (vec_valid) next_state = WAIT;
            WAIT:    if (settle_cnt == '0) next_state = exp_last ? DONE : IDLE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake and completion flags decode straight from the state.
    always_comb begin
        vec_ready = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:    vec_ready = 1'b1;
            DONE:    done      = 1'b1;
            default: ;
        endcase
    end

    // Vector capture, settle countdown, verdict and tally updates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_f            <= '0;
            alu_a            <= '0;
            alu_b            <= '0;
            exp_y            <= '0;
            exp_zero         <= 1'b0;
            exp_last         <= 1'b0;
            settle_cnt       <= '0;
            idx              <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            mismatch         <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (accept) begin
                alu_f      <= vec_f;
                alu_a      <= vec_a;
                alu_b      <= vec_b;
                exp_y      <= vec_y;
                exp_zero   <= vec_zero;
                exp_last   <= vec_last;
                settle_cnt <= SETTLE_LD;
            end else if (state == WAIT && !sample) begin
                settle_cnt <= settle_cnt - 1'b1;
            end else if (sample) begin
                if (match) begin
                    pass_cnt <= sat_inc(pass_cnt);
                end else begin
                    fail_cnt <= sat_inc(fail_cnt);
                    mismatch <= 1'b1;
                    if (!first_fail_valid) begin
                        first_fail_idx   <= idx;
                        first_fail_valid <= 1'b1;
                    end
                end
                idx <= sat_inc(idx);
            end
        end
    end

endmodule

// File: tb/tb_alu_check_stage.sv
// Bench for alu_check_stage: two instances (SETTLE=1/CNT_W=8 and
// SETTLE=3/CNT_W=2), each wrapped around a behavioural ALU, checked every
// cycle against a timing/scoreboard model plus literal end-of-run values.
module tb_alu_check_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Stimulus, one slot per DUT.
    logic [1:0]       vvalid, vz, vlast, xflag;
    logic [1:0][2:0]  vf;
    logic [1:0][31:0] va, vb, vy;

    // DUT outputs.
    logic [1:0]       rdy, mis, dn, ffv;
    logic [1:0][2:0]  af;
    logic [1:0][31:0] aa, ab;
    logic [7:0]       pc0, fc0, fi0;
    logic [1:0]       pc1, fc1, fi1;

    // Behavioural ALU returning {zero, y}.
    function automatic logic [32:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] y;
        case (f)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = a + b;
            3'b011:  y = a ^ b;
            3'b100:  y = a & ~b;
            3'b101:  y = a | ~b;
            3'b110:  y = a - b;
            default: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        return {(y == 32'd0), y};
    endfunction

    logic [32:0] r0, r1;
    logic [31:0] ay0, ay1;
    assign r0  = alu_fn(af[0], aa[0], ab[0]);
    assign r1  = alu_fn(af[1], aa[1], ab[1]);
    // Poisoned result: top bit unknown, remaining bits wrong.
    assign ay0 = xflag[0] ? {1'bx, ~r0[30:0]} : r0[31:0];
    assign ay1 = xflag[1] ? {1'bx, ~r1[30:0]} : r1[31:0];

    alu_check_stage #(.WIDTH(32), .CNT_W(8), .SETTLE(1)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vvalid[0]), .vec_ready(rdy[0]), .vec_f(vf[0]), .vec_a(va[0]),
        .vec_b(vb[0]), .vec_y(vy[0]), .vec_zero(vz[0]), .vec_last(vlast[0]),
        .alu_f(af[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_y(ay0), .alu_zero(r0[32]),
        .pass_cnt(pc0), .fail_cnt(fc0), .first_fail_idx(fi0),
        .first_fail_valid(ffv[0]), .mismatch(mis[0]), .done(dn[0])
    );

    alu_check_stage #(.WIDTH(32), .CNT_W(2), .SETTLE(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vvalid[1]), .vec_ready(rdy[1]), .vec_f(vf[1]), .vec_a(va[1]),
        .vec_b(vb[1]), .vec_y(vy[1]), .vec_zero(vz[1]), .vec_last(vlast[1]),
        .alu_f(af[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_y(ay1), .alu_zero(r1[32]),
        .pass_cnt(pc1), .fail_cnt(fc1), .first_fail_idx(fi1),
        .first_fail_valid(ffv[1]), .mismatch(mis[1]), .done(dn[1])
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         settle_of [2] = '{1, 3};
    int         cmax      [2] = '{255, 3};
    int         m_wait [2], m_pass [2], m_fail [2], m_idx [2], m_ffi [2];
    bit         m_ffv [2], m_mis [2], m_done [2], q_z [2], q_last [2];
    logic [2:0] m_af [2];
    logic [31:0] m_aa [2], m_ab [2], q_y [2];
    int         cyc    = 0;
    bit         m_init = 0;

    function automatic int inc_sat(input int v, input int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    task automatic model_step(input int d);
        bit ready_now, ok;
        if (!rst_n) begin
            m_wait[d] = 0; m_pass[d] = 0; m_fail[d] = 0; m_idx[d] = 0; m_ffi[d] = 0;
            m_ffv[d] = 0; m_mis[d] = 0; m_done[d] = 0; q_z[d] = 0; q_last[d] = 0;
            m_af[d] = '0; m_aa[d] = '0; m_ab[d] = '0; q_y[d] = '0;
        end else begin
            ready_now = !m_done[d] && m_wait[d] == 0;
            m_mis[d] = 0;
            if (m_wait[d] > 0) begin
                m_wait[d]--;
                if (m_wait[d] == 0) begin
                    ok = !xflag[d] && (alu_fn(m_af[d], m_aa[d], m_ab[d]) == {q_z[d], q_y[d]});
                    if (ok) m_pass[d] = inc_sat(m_pass[d], cmax[d]);
                    else begin
                        m_fail[d] = inc_sat(m_fail[d], cmax[d]);
                        m_mis[d]  = 1;
                        if (!m_ffv[d]) begin m_ffv[d] = 1; m_ffi[d] = m_idx[d]; end
                    end
                    m_idx[d] = inc_sat(m_idx[d], cmax[d]);
                    if (q_last[d]) m_done[d] = 1;
                end
            end else if (ready_now && vvalid[d]) begin
                m_af[d] = vf[d]; m_aa[d] = va[d]; m_ab[d] = vb[d];
                q_y[d] = vy[d]; q_z[d] = vz[d]; q_last[d] = vlast[d];
                m_wait[d] = settle_of[d];
            end
        end
    endtask

    // Model advances on the same edges as the DUTs.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) model_step(d);
        cyc++;
        m_init = 1;
    end

    // Every-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (m_init) begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] p, f, i;
                p = (d == 0) ? pc0 : {6'd0, pc1};
                f = (d == 0) ? fc0 : {6'd0, fc1};
                i = (d == 0) ? fi0 : {6'd0, fi1};
                chk($sformatf("d%0d vec_ready", d), rdy[d], (!m_done[d] && m_wait[d] == 0));
                chk($sformatf("d%0d pass_cnt", d), p, m_pass[d]);
                chk($sformatf("d%0d fail_cnt", d), f, m_fail[d]);
                chk($sformatf("d%0d first_fail_idx", d), i, m_ffi[d]);
                chk($sformatf("d%0d first_fail_valid", d), ffv[d], m_ffv[d]);
                chk($sformatf("d%0d mismatch", d), mis[d], m_mis[d]);
                chk($sformatf("d%0d done", d), dn[d], m_done[d]);
                chk($sformatf("d%0d alu_f", d), af[d], m_af[d]);
                chk($sformatf("d%0d alu_a", d), aa[d], m_aa[d]);
                chk($sformatf("d%0d alu_b", d), ab[d], m_ab[d]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode: 0 correct expectations, 1 random corruption, 2 flip expected zero.
    task automatic send(input int d, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int mode, input bit last, output int acc);
        logic [32:0] r;
        int n;
        r = alu_fn(f, a, b);
        if (mode == 2) r[32] = ~r[32];
        else if (mode == 1) begin
            if ($urandom_range(0, 1) == 1) r[32] = ~r[32];
            else r[31:0] = r[31:0] ^ (32'd1 << $urandom_range(0, 31));
        end
        @(negedge clk);
        vvalid[d] = 1'b1; vf[d] = f; va[d] = a; vb[d] = b;
        vy[d] = r[31:0]; vz[d] = r[32]; vlast[d] = last;
        n = 0;
        while (rdy[d] !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            n_checks++; n_fail++;
            $display("FAIL d%0d handshake: vec_ready never rose within 64 cycles", d);
        end
        acc = cyc;
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vvalid = '0; xflag = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic rand_vec(output logic [2:0] f, output logic [31:0] a, output logic [31:0] b);
        f = 3'($urandom_range(0, 7));
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
    endtask

    initial begin
        int t, prev;
        logic [2:0] f;
        logic [31:0] a, b;
        vvalid = '0; vz = '0; vlast = '0; xflag = '0;
        vf = '0; va = '0; vb = '0; vy = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        chk("reset vec_ready", rdy[0], 1);
        chk("reset pass_cnt", pc0, 0);
        chk("reset fail_cnt", fc0, 0);
        chk("reset done", dn[0], 0);
        chk("reset alu_a", aa[0], 0);

        // 5+7=12, last vector: verdict and done one cycle after the accept edge.
        send(0, 3'b010, 32'd5, 32'd7, 0, 1, t);
        repeat (2) @(negedge clk);
        chk("t1 pass_cnt", pc0, 1);
        chk("t1 fail_cnt", fc0, 0);
        chk("t1 done", dn[0], 1);
        vvalid[0] = 1'b0;

        // 9-9 gives zero: correct expectation passes.
        do_reset();
        send(0, 3'b110, 32'd9, 32'd9, 0, 1, t);
        repeat (2) @(negedge clk);
        chk("t2a pass_cnt", pc0, 1);
        chk("t2a fail_cnt", fc0, 0);

        // Same vector, expected zero=0: mismatch pulse, first failure at 0.
        do_reset();
        send(0, 3'b110, 32'd9, 32'd9, 2, 1, t);
        @(negedge clk);
        @(negedge clk);
        chk("t2b mismatch", mis[0], 1);
        chk("t2b fail_cnt", fc0, 1);
        chk("t2b first_fail_idx", fi0, 0);
        chk("t2b first_fail_valid", ffv[0], 1);

        // 21 vectors, #4 and #9 corrupted.
        do_reset();
        for (int i = 0; i < 21; i++) begin
            rand_vec(f, a, b);
            send(0, f, a, b, (i == 4 || i == 9) ? 1 : 0, i == 20, t);
        end
        repeat (3) @(negedge clk);
        chk("t3 pass_cnt", pc0, 19);
        chk("t3 fail_cnt", fc0, 2);
        chk("t3 first_fail_idx", fi0, 4);
        chk("t3 done", dn[0], 1);

        // Reset during WAIT discards the in-flight (failing) vector.
        do_reset();
        send(0, 3'b010, 32'd5, 32'd7, 1, 0, t);
        @(negedge clk);
        rst_n = 1'b0; vvalid[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5 fail_cnt", fc0, 0);
        chk("t5 mismatch", mis[0], 0);
        chk("t5 vec_ready", rdy[0], 1);
        @(negedge clk);
        chk("t5 mismatch later", mis[0], 0);
        send(0, 3'b000, 32'hF0, 32'h3C, 2, 1, t);
        repeat (2) @(negedge clk);
        chk("t5 idx restart", fi0, 0);
        chk("t5 fail after", fc0, 1);

        // Unknown bits on the ALU result count as a mismatch.
        do_reset();
        xflag[0] = 1'b1;
        send(0, 3'b010, 32'd5, 32'd7, 0, 1, t);
        repeat (2) @(negedge clk);
        chk("tx fail_cnt", fc0, 1);
        chk("tx pass_cnt", pc0, 0);
        xflag[0] = 1'b0;

        // SETTLE=3 with valid held high: one accept every 4 cycles; CNT_W=2 saturates.
        do_reset();
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            send(1, 3'b010, 32'(i + 1), 32'd2, 0, i == 4, t);
            if (i > 0) chk("t4 accept spacing", t - prev, 4);
            prev = t;
        end
        repeat (5) @(negedge clk);
        chk("t6 pass_cnt sat", pc1, 3);
        chk("t6 fail_cnt", fc1, 0);
        chk("t6 done", dn[1], 1);
        vvalid[1] = 1'b0;

        // Random runs with idle gaps and random corruption on both instances.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk);
                vvalid[0] = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
            rand_vec(f, a, b);
            send(0, f, a, b, ($urandom_range(0, 3) == 0) ? 1 : 0, i == 39, t);
        end
        for (int i = 0; i < 12; i++) begin
            rand_vec(f, a, b);
            send(1, f, a, b, ($urandom_range(0, 2) == 0) ? 1 : 0, i == 11, t);
        end
        repeat (6) @(negedge clk);
        vvalid = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
